jk_bank_ctrl: RTL

- Command-driven sequencer for a bank of WIDTH JK flip-flops; every state change goes through J/K encodings (00 hold, 01 clear, 10 set, 11 toggle).
- Accepts one command at a time over a valid/ready handshake: single-bit set/clear/toggle, bank clear, or a multi-step synchronous up/down count built from JK toggle equations.
- Sits between a host/test sequencer and flip-flop-based register or counter logic in the sequential-circuit library.

---
 rtl/jk_bank_ctrl_if.sv | 15 +
 rtl/jk_bank_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl_if.sv
// Command handshake bundle for jk_bank_ctrl: the host drives the command,
// the controller returns ready.
interface jk_bank_ctrl_if #(
  parameter int IDXW = 2,
  parameter int CNTW = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [IDXW-1:0] cmd_idx;
  logic [CNTW-1:0] cmd_count;

  modport master (output cmd_valid, cmd_op, cmd_idx, cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_count, output cmd_ready);
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of WIDTH JK flip-flops; every change of q goes through J/K.
// Define JK_BANK_WRAP_EN to get a one-cycle wrap pulse after a counting step that overflows.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wrap
);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_SET    = 3'b001;
  localparam logic [2:0] OP_CLR    = 3'b010;
  localparam logic [2:0] OP_TOG    = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;
  localparam logic [2:0] OP_CLRALL = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;
  localparam logic [IDXW:0] WIDTH_L = (IDXW+1)'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      op_r;
  logic [IDXW-1:0] idx_r;
  logic [CNTW-1:0] cnt_r;
  logic            illegal_r, illegal_s;
  logic            accept_s;
  logic [WIDTH-1:0] q_r, j_s, k_s, tog_s;

  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] j,
                                               input logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   nxt[i] = cur[i];
        2'b01:   nxt[i] = 1'b0;
        2'b10:   nxt[i] = 1'b1;
        2'b11:   nxt[i] = ~cur[i];
        default: nxt[i] = cur[i];
      endcase
    end
    return nxt;
  endfunction

  assign accept_s      = cmd.cmd_valid && (state_r == ST_IDLE);
  assign cmd.cmd_ready = (state_r == ST_IDLE);
  assign busy          = (state_r != ST_IDLE);
  assign done          = (state_r == ST_DONE);
  assign err           = (state_r == ST_DONE) && illegal_r;
  assign q             = q_r;
  assign qn            = ~q_r;
  assign j_vec         = j_s;
  assign k_vec         = k_s;

  // Classify the incoming command as illegal (out-of-range index or reserved op)
  always_comb begin
    illegal_s = 1'b0;
    case (cmd.cmd_op)
      OP_SET, OP_CLR, OP_TOG: illegal_s = ({1'b0, cmd.cmd_idx} >= WIDTH_L);
      OP_RSVD:                illegal_s = 1'b1;
      default:                illegal_s = 1'b0;
    endcase
  end

  // Synchronous-counter toggle terms: a bit flips when every lower bit is 1 (up) or 0 (down)
  always_comb begin : count_toggles
    logic run_s;
    tog_s = {WIDTH{1'b0}};
    run_s = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog_s[i] = run_s;
      if (op_r == OP_UP) begin
        run_s = run_s & q_r[i];
      end else begin
        run_s = run_s & ~q_r[i];
      end
    end
  end

  // Next-state and J/K decode
  always_comb begin
    state_s = state_r;
    j_s     = {WIDTH{1'b0}};
    k_s     = {WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if ((cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DOWN)) begin
            if (cmd.cmd_count == {CNTW{1'b0}}) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_COUNT;
            end
          end else begin
            state_s = ST_APPLY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        state_s = ST_DONE;
        if (!illegal_r) begin
          case (op_r)
            OP_SET:    j_s[idx_r] = 1'b1;
            OP_CLR:    k_s[idx_r] = 1'b1;
            OP_TOG: begin
              j_s[idx_r] = 1'b1;
              k_s[idx_r] = 1'b1;
            end
            OP_CLRALL: k_s = {WIDTH{1'b1}};
            OP_HOLD:   k_s = {WIDTH{1'b0}};
            default:   k_s = {WIDTH{1'b0}};
          endcase
        end else begin
          k_s = {WIDTH{1'b0}};
        end
      end
      ST_COUNT: begin
        j_s = tog_s;
        k_s = tog_s;
        if (cnt_r == CNTW'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_COUNT;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, bank and latched command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      q_r       <= {WIDTH{1'b0}};
      op_r      <= OP_HOLD;
      idx_r     <= {IDXW{1'b0}};
      cnt_r     <= {CNTW{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= jk_next(q_r, j_s, k_s);
      if (accept_s) begin
        op_r      <= cmd.cmd_op;
        idx_r     <= cmd.cmd_idx;
        cnt_r     <= cmd.cmd_count;
        illegal_r <= illegal_s;
      end else if (state_r == ST_COUNT) begin
        cnt_r <= cnt_r - CNTW'(1);
      end
    end
  end

`ifdef JK_BANK_WRAP_EN
  logic wrap_r, wrap_s;

  // A counting step wraps when leaving all-ones going up or all-zeros going down
  always_comb begin
    wrap_s = 1'b0;
    if (state_r == ST_COUNT) begin
      if (op_r == OP_UP) begin
        wrap_s = &q_r;
      end else begin
        wrap_s = ~|q_r;
      end
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Register the wrap pulse so it appears in the cycle after the wrapping step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_s;
    end
  end

  assign wrap = wrap_r;
`else
  assign wrap = 1'b0;
`endif

endmodule
